// File: rtl/des_undo_log_writer_if.sv
// des_undo_log_writer_if: AXI write port (AW/W/B) carrying undo-log bursts to memory.
interface des_undo_log_writer_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  modport master(
    output awvalid, awaddr, awlen, awsize, wvalid, wdata, wstrb, wlast, bready,
    input  awready, wready, bvalid, bresp
  );
  modport slave(
    input  awvalid, awaddr, awlen, awsize, wvalid, wdata, wstrb, wlast, bready,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/des_undo_log_writer.sv
// des_undo_log_writer: buffers undo-log entries and writes each as a 2-beat {addr, old data} AXI burst to its slot.
module des_undo_log_writer #(
  parameter int UNDO_LOG_ADDR_WIDTH = 32,
  parameter int UNDO_LOG_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH          = 4,
  parameter int MAX_ENTRIES         = 64
) (
  input  logic                                             ap_clk,
  input  logic                                             ap_rst,
  input  logic [UNDO_LOG_ADDR_WIDTH+UNDO_LOG_DATA_WIDTH-1:0] undo_log_entry,
  input  logic                                             undo_log_entry_ap_vld,
  output logic                                             undo_log_entry_ap_rdy,
  input  logic                                             task_start,
  input  logic [31:0]                                      log_base,
  des_undo_log_writer_if.master                            m_axi_log,
  output logic [6:0]                                       log_count,
  output logic                                             drained,
  output logic                                             overflow,
  output logic                                             bresp_err
);
  localparam int AW = UNDO_LOG_ADDR_WIDTH;
  localparam int DW = UNDO_LOG_DATA_WIDTH;
  localparam int EW = AW + DW + 7;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [6:0]  MAX_C  = 7'(MAX_ENTRIES);
  localparam logic [PW:0] FULL_C = (PW+1)'(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, AWS, W0, W1, BS} state_t;
  state_t state, state_n;
  logic [EW-1:0]   fifo [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     occ;
  logic            empty, full, push, pop;
  logic [EW-1:0]   head;
  logic [DW-1:0]   data_q;
  logic [31:0]     awaddr_q, wdata_q;
  assign empty = occ == '0;
  assign full  = occ == FULL_C;
  assign undo_log_entry_ap_rdy = !full && (log_count < MAX_C);
  assign push  = undo_log_entry_ap_vld && undo_log_entry_ap_rdy;
  assign pop   = state == IDLE && !empty;
  assign head  = fifo[rd_ptr];
  assign drained = empty && state == IDLE;
  assign m_axi_log.awvalid = state == AWS;
  assign m_axi_log.awaddr  = awaddr_q;
  assign m_axi_log.awlen   = 8'd1;
  assign m_axi_log.awsize  = 3'b010;
  assign m_axi_log.wvalid  = state == W0 || state == W1;
  assign m_axi_log.wdata   = wdata_q;
  assign m_axi_log.wstrb   = 4'hF;
  assign m_axi_log.wlast   = state == W1;
  assign m_axi_log.bready  = state == BS;
  // Slot is fixed at enqueue time; a same-cycle task_start restarts numbering at 0.
  always_ff @(posedge ap_clk)
    if (push) fifo[wr_ptr] <= {undo_log_entry, task_start ? 7'd0 : log_count};
  always_ff @(posedge ap_clk or posedge ap_rst)
    if (ap_rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      log_count <= '0;
      overflow  <= 1'b0;
      bresp_err <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      data_q    <= '0;
    end else begin
      state  <= state_n;
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      occ    <= occ + (PW+1)'(push) - (PW+1)'(pop);
      if (push) log_count <= task_start ? 7'd1 : log_count + 7'd1;
      else if (task_start) log_count <= '0;
      if (undo_log_entry_ap_vld && log_count == MAX_C) overflow <= 1'b1;
      if (state == BS && m_axi_log.bvalid && m_axi_log.bresp != 2'b00) bresp_err <= 1'b1;
      if (pop) begin
        awaddr_q <= log_base + {22'd0, head[6:0], 3'd0};
        wdata_q  <= 32'(head[AW+6:7]);
        data_q   <= head[EW-1:AW+7];
      end
      if (state == W0 && m_axi_log.wready) wdata_q <= 32'(data_q);
    end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = empty ? IDLE : AWS;
      AWS:     state_n = m_axi_log.awready ? W0 : AWS;
      W0:      state_n = m_axi_log.wready ? W1 : W0;
      W1:      state_n = m_axi_log.wready ? BS : W1;
      BS:      state_n = m_axi_log.bvalid ? IDLE : BS;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_des_undo_log_writer.sv
// tb_des_undo_log_writer: directed stimulus with a scoreboard of expected AW addresses and W beats.
module tb_des_undo_log_writer;
  logic        clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic [63:0] undo_log_entry = '0;
  logic        vld = 1'b0;
  logic        rdy;
  logic        task_start = 1'b0;
  logic [31:0] log_base = 32'h1000;
  logic [6:0]  log_count;
  logic        drained, overflow, bresp_err;
  logic        aw_stall = 1'b0;
  logic        w_stall = 1'b0;
  int          bcount = 0;
  int          err_target = -1;
  int          checks = 0;
  int          errors = 0;
  int          mcount = 0;
  logic [31:0] exp_aw [$];
  logic [32:0] exp_w  [$];

  des_undo_log_writer_if axi();

  des_undo_log_writer dut (
    .ap_clk(clk), .ap_rst(ap_rst),
    .undo_log_entry(undo_log_entry),
    .undo_log_entry_ap_vld(vld),
    .undo_log_entry_ap_rdy(rdy),
    .task_start(task_start),
    .log_base(log_base),
    .m_axi_log(axi),
    .log_count(log_count),
    .drained(drained),
    .overflow(overflow),
    .bresp_err(bresp_err)
  );

  always #5 clk = ~clk;

  assign axi.awready = !aw_stall;
  assign axi.wready  = !w_stall;
  assign axi.bresp   = (bcount == err_target) ? 2'b10 : 2'b00;

  always @(posedge clk or posedge ap_rst)
    if (ap_rst) axi.bvalid <= 1'b0;
    else begin
      if (axi.bvalid && axi.bready) begin
        axi.bvalid <= 1'b0;
        bcount <= bcount + 1;
      end else if (axi.wvalid && axi.wready && axi.wlast) axi.bvalid <= 1'b1;
    end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  always @(negedge clk)
    if (!ap_rst) begin
      if (axi.awvalid && axi.awready) begin
        if (exp_aw.size() == 0) chk("aw_unexpected", axi.awaddr, 32'hFFFF_FFFF);
        else chk("awaddr", axi.awaddr, exp_aw.pop_front());
        chk("awlen", 32'(axi.awlen), 32'd1);
        chk("awsize", 32'(axi.awsize), 32'd2);
      end
      if (axi.wvalid && axi.wready) begin
        if (exp_w.size() == 0) chk("w_unexpected", axi.wdata, 32'hFFFF_FFFF);
        else begin
          logic [32:0] e;
          e = exp_w.pop_front();
          chk("wdata", axi.wdata, e[31:0]);
          chk("wlast", 32'(axi.wlast), 32'(e[32]));
          chk("wstrb", 32'(axi.wstrb), 32'hF);
        end
      end
    end

  // Called at posedge+#1; returns at posedge+#1 right after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input bit ts);
    bit ok;
    int slot;
    ok = 0;
    vld = 1'b1;
    undo_log_entry = {d, a};
    task_start = ts;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (rdy) begin
        slot = ts ? 0 : mcount;
        mcount = ts ? 1 : mcount + 1;
        exp_aw.push_back(log_base + 32'(slot * 8));
        exp_w.push_back({1'b0, a});
        exp_w.push_back({1'b1, d});
        ok = 1;
      end
      @(posedge clk);
      #1;
    end
    vld = 1'b0;
    task_start = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drained();
    bit ok;
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (drained) ok = 1;
    end
    @(posedge clk);
    #1;
    if (!ok) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(rdy), 32'd1);
    chk("rst_log_count", 32'(log_count), 32'd0);
    chk("rst_drained", 32'(drained), 32'd1);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_bresp_err", 32'(bresp_err), 32'd0);
    chk("rst_awvalid", 32'(axi.awvalid), 32'd0);
    chk("rst_wvalid", 32'(axi.wvalid), 32'd0);
    chk("rst_bready", 32'(axi.bready), 32'd0);
    chk("rst_awaddr", axi.awaddr, 32'd0);
    chk("rst_wdata", axi.wdata, 32'd0);
    ap_rst = 1'b0;
    @(posedge clk);
    #1;
    // single entry, zero-wait slave
    send(32'h40, 32'h0123_0005, 1);
    chk("single_log_count", 32'(log_count), 32'd1);
    chk("single_drained_fall", 32'(drained), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("single_drained_5", 32'(drained), 32'd0);
    @(posedge clk);
    #1;
    chk("single_drained_6", 32'(drained), 32'd1);
    // back-to-back with AW stalled: one entry in the FSM, four fill the FIFO
    aw_stall = 1'b1;
    send(32'h50, 32'hA0, 1);
    for (int i = 1; i < 5; i++) send(32'h50 + i, 32'hA0 + i, 0);
    chk("stall_rdy_full", 32'(rdy), 32'd0);
    chk("stall_log_count", 32'(log_count), 32'd5);
    fork begin repeat (15) @(posedge clk); #1; aw_stall = 1'b0; end join_none
    send(32'h55, 32'hA5, 0);
    wait_drained();
    chk("stall_log_count6", 32'(log_count), 32'd6);
    // task_start coinciding with an accept while earlier entries are queued
    log_base = 32'h2000;
    aw_stall = 1'b1;
    send(32'hA, 32'h1, 1);
    send(32'hB, 32'h2, 0);
    send(32'hC, 32'h3, 0);
    chk("ts_log_count3", 32'(log_count), 32'd3);
    send(32'hD, 32'h4, 1);
    chk("ts_log_count1", 32'(log_count), 32'd1);
    aw_stall = 1'b0;
    wait_drained();
    // fill all slots; slot addresses wrap past 2^32
    log_base = 32'hFFFF_FF00;
    for (int i = 0; i < 64; i++) send(32'h100 + i, 32'hD000_0000 + i, i == 0);
    wait_drained();
    chk("ovf_log_count64", 32'(log_count), 32'd64);
    chk("ovf_rdy", 32'(rdy), 32'd0);
    chk("ovf_not_yet", 32'(overflow), 32'd0);
    vld = 1'b1;
    undo_log_entry = {32'hEEEE, 32'h200};
    repeat (2) @(posedge clk);
    #1;
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_rdy_held", 32'(rdy), 32'd0);
    chk("ovf_count_held", 32'(log_count), 32'd64);
    vld = 1'b0;
    task_start = 1'b1;
    @(posedge clk);
    #1;
    task_start = 1'b0;
    mcount = 0;
    chk("ovf_ts_clear", 32'(log_count), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    send(32'h200, 32'hEEEE, 0);
    wait_drained();
    chk("ovf_after_count", 32'(log_count), 32'd1);
    // error response on the second of three bursts
    log_base = 32'h1000;
    chk("err_before", 32'(bresp_err), 32'd0);
    err_target = bcount + 1;
    send(32'h61, 32'hB1, 1);
    send(32'h62, 32'hB2, 0);
    send(32'h63, 32'hB3, 0);
    wait_drained();
    chk("err_set", 32'(bresp_err), 32'd1);
    send(32'h64, 32'hB4, 0);
    wait_drained();
    chk("err_sticky", 32'(bresp_err), 32'd1);
    // async reset while holding the first W beat
    w_stall = 1'b1;
    send(32'h77, 32'h88, 1);
    begin
      bit ok;
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
        @(negedge clk);
        if (axi.wvalid) ok = 1;
      end
      if (!ok) chk("w0_timeout", 32'd0, 32'd1);
    end
    ap_rst = 1'b1;
    exp_w.delete();
    #1;
    chk("arst_awvalid", 32'(axi.awvalid), 32'd0);
    chk("arst_wvalid", 32'(axi.wvalid), 32'd0);
    chk("arst_bready", 32'(axi.bready), 32'd0);
    chk("arst_log_count", 32'(log_count), 32'd0);
    chk("arst_drained", 32'(drained), 32'd1);
    chk("arst_bresp_err", 32'(bresp_err), 32'd0);
    mcount = 0;
    w_stall = 1'b0;
    @(posedge clk);
    #1;
    ap_rst = 1'b0;
    @(posedge clk);
    #1;
    log_base = 32'h3000;
    send(32'h11, 32'hAA, 0);
    send(32'h12, 32'hBB, 0);
    wait_drained();
    chk("post_rst_count", 32'(log_count), 32'd2);
    chk("aw_queue_empty", 32'(exp_aw.size()), 32'd0);
    chk("w_queue_empty", 32'(exp_w.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
